// File: rtl/alu_sequencer.sv
// Instruction sequencer that owns the register file and NZVC flags and drives an external
// combinational 8-bit ALU. It adds LDI and a shift-add MUL on top of the ALU's eight operations.
module alu_sequencer #(
  parameter int NREG      = 4,
  parameter int MUL_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [7:0] cmd_imm,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_result,
  input  logic [3:0] alu_nzvc,
  output logic [3:0] flags,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    regs [NREG];
  logic [3:0]    op_q;
  logic [1:0]    rd_q;
  logic [7:0]    imm_q;
  // During MUL, opa is the shifting multiplicand and opb the shifting multiplier.
  logic [7:0]    opa, opb;
  logic [7:0]    acc;
  logic          lost, cy, err;
  logic [CW-1:0] cnt;

  logic          accept;
  logic [7:0]    acc_next;
  logic          cy_next;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_err   = rsp_valid && err;
  assign dbg_data  = regs[dbg_sel];

  // A partial product is added only when the current multiplier bit is set; a carry out of the
  // ADD, or any multiplicand bit already shifted past bit 7, means the product overflows a byte.
  assign acc_next = opb[0] ? alu_result : acc;
  assign cy_next  = cy | (opb[0] & (alu_nzvc[0] | lost));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal assigned in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid) state_d = (cmd_op == 4'd9) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_DONE;
      S_MUL:  if (cnt == CNT_LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    unique case (state_q)
      S_EXEC: begin
        alu_a   = opa;
        alu_b   = opb;
        alu_sel = op_q[2:0];
      end
      S_MUL: begin
        alu_a   = acc;
        alu_b   = opa;
        alu_sel = 3'b000;
      end
      default: ;
    endcase
  end

  // NOTE: the register file is reset explicitly because its cleared contents are architecturally visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      flags <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      imm_q <= '0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      lost  <= 1'b0;
      cy    <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          op_q  <= cmd_op;
          rd_q  <= cmd_rd;
          imm_q <= cmd_imm;
          opa   <= regs[cmd_ra];
          opb   <= regs[cmd_rb];
          acc   <= '0;
          lost  <= 1'b0;
          cy    <= 1'b0;
          cnt   <= '0;
          err   <= 1'b0;
        end
        S_EXEC: begin
          unique case (op_q)
            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
              regs[rd_q] <= alu_result;
              flags      <= alu_nzvc;
            end
            4'd2, 4'd3: begin
              regs[rd_q] <= alu_result;
              flags[3:2] <= alu_nzvc[3:2];
            end
            4'd8: begin
              regs[rd_q] <= imm_q;
              flags[3]   <= imm_q[7];
              flags[2]   <= (imm_q == 8'h00);
            end
            default: err <= 1'b1;
          endcase
        end
        S_MUL: begin
          acc  <= acc_next;
          cy   <= cy_next;
          lost <= lost | opa[7];
          opa  <= opa << 1;
          opb  <= opb >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            regs[rd_q] <= acc_next;
            flags      <= {acc_next[7], (acc_next == 8'h00), 1'b0, cy_next};
          end
        end
        S_DONE: err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: the bench plays the ALU and keeps a shadow register file
// whose expected responses are queued at issue and compared when rsp_valid arrives.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [7:0] cmd_imm;
  logic       rsp_valid, rsp_err;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic [3:0] alu_nzvc;
  logic [3:0] flags;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  typedef struct {
    logic       err;
    logic [1:0] rd;
    logic [7:0] val;
    logic [3:0] flags;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] sh_regs [4];
  logic [3:0] sh_flags;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_nzvc(alu_nzvc),
    .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Reference ALU: 0 ADD, 1 SUB (C = borrow), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR.
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] sel);
    logic [8:0] t;
    logic [7:0] r;
    logic       v, c;
    t = {1'b0, a} + {1'b0, b};
    r = '0;
    v = 1'b0;
    c = 1'b0;
    case (sel)
      3'd0: begin r = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = a << 1; c = a[7]; end
      default: begin r = a >> 1; c = a[0]; end
    endcase
    return {r[7], (r == 8'h00), v, c, r};
  endfunction

  always_comb {alu_nzvc, alu_result} = alu_f(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [7:0] imm);
    exp_t        e;
    logic [11:0] r;
    logic [15:0] p;
    logic [7:0]  a, b;
    int          n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 16'(cmd_ready), 16'd1);
    a     = sh_regs[ra];
    b     = sh_regs[rb];
    r     = alu_f(a, b, op[2:0]);
    e.err = 1'b0;
    e.rd  = rd;
    e.lat = (op == 4'd9) ? 9 : 2;
    case (op)
      4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
        sh_regs[rd] = r[7:0];
        sh_flags    = r[11:8];
      end
      4'd2, 4'd3: begin
        sh_regs[rd]   = r[7:0];
        sh_flags[3:2] = r[11:10];
      end
      4'd8: begin
        sh_regs[rd] = imm;
        sh_flags[3] = imm[7];
        sh_flags[2] = (imm == 8'h00);
      end
      4'd9: begin
        p           = 16'(a) * 16'(b);
        sh_regs[rd] = p[7:0];
        sh_flags    = {p[7], (p[7:0] == 8'h00), 1'b0, (p > 16'd255)};
      end
      default: e.err = 1'b1;
    endcase
    e.val   = sh_regs[rd];
    e.flags = sh_flags;
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_ra    = ra;
    cmd_rb    = rb;
    cmd_imm   = imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    exp_t e;
    int   lat;
    lat = 0;
    if (sb.size() == 0) begin
      check("sb_empty", 16'(sb.size()), 16'd1);
      return;
    end
    dbg_sel = sb[0].rd;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    e = sb.pop_front();
    if (!rsp_valid) begin
      check("rsp_timeout", 16'(rsp_valid), 16'd1);
      return;
    end
    check("rsp_err", 16'(rsp_err), 16'(e.err));
    check("latency", 16'(lat), 16'(e.lat));
    check("flags", 16'(flags), 16'(e.flags));
    check("rd_value", 16'(dbg_data), 16'(e.val));
  endtask

  task automatic run(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                     input logic [1:0] rb, input logic [7:0] imm);
    issue(op, rd, ra, rb, imm);
    wait_rsp();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, 16'(cmd_ready), 16'd1);
    check({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
    check({tag, "_flags"}, 16'(flags), 16'd0);
    check({tag, "_alu"}, {5'd0, alu_sel, alu_a}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 check({tag, "_reg"}, 16'(dbg_data), 16'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_ra    = '0;
    cmd_rb    = '0;
    cmd_imm   = '0;
    dbg_sel   = '0;
    for (int i = 0; i < 4; i++) sh_regs[i] = 8'h00;
    sh_flags = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    // Signed overflow on ADD
    run(4'd8, 2'd0, 2'd0, 2'd0, 8'h7F);
    run(4'd8, 2'd1, 2'd0, 2'd0, 8'h01);
    run(4'd0, 2'd2, 2'd0, 2'd1, 8'h00);
    check("add_flags_1010", 16'(flags), 16'b1010);
    check("add_r2_80", 16'(dbg_data), 16'h80);

    // SUB to zero, then LDI keeps V/C
    run(4'd8, 2'd0, 2'd0, 2'd0, 8'h05);
    run(4'd1, 2'd3, 2'd0, 2'd0, 8'h00);
    check("sub_flags_0100", 16'(flags), 16'b0100);
    run(4'd8, 2'd1, 2'd0, 2'd0, 8'hF0);
    check("ldi_flags_1000", 16'(flags), 16'b1000);

    // Carry from ADD survives a logical op
    run(4'd8, 2'd0, 2'd0, 2'd0, 8'hFF);
    run(4'd8, 2'd1, 2'd0, 2'd0, 8'h01);
    run(4'd0, 2'd2, 2'd0, 2'd1, 8'h00);
    run(4'd8, 2'd0, 2'd0, 2'd0, 8'hF0);
    run(4'd8, 2'd1, 2'd0, 2'd0, 8'h0F);
    run(4'd2, 2'd3, 2'd0, 2'd1, 8'h00);
    check("and_flags_0101", 16'(flags), 16'b0101);

    // MUL: plain, overflow to zero, full byte with no carry
    run(4'd8, 2'd0, 2'd0, 2'd0, 8'h0D);
    run(4'd8, 2'd1, 2'd0, 2'd0, 8'h0B);
    run(4'd9, 2'd2, 2'd0, 2'd1, 8'h00);
    check("mul_8f", {flags, 4'd0, dbg_data}, {4'b1000, 4'd0, 8'h8F});
    run(4'd8, 2'd0, 2'd0, 2'd0, 8'h10);
    run(4'd9, 2'd3, 2'd0, 2'd0, 8'h00);
    check("mul_256", {flags, 4'd0, dbg_data}, {4'b0101, 4'd0, 8'h00});
    run(4'd8, 2'd0, 2'd0, 2'd0, 8'hFF);
    run(4'd8, 2'd1, 2'd0, 2'd0, 8'h01);
    run(4'd9, 2'd2, 2'd0, 2'd1, 8'h00);
    check("mul_ff", {flags, 4'd0, dbg_data}, {4'b1000, 4'd0, 8'hFF});
    run(4'd9, 2'd0, 2'd0, 2'd0, 8'h00);

    // Mixed operations with rd aliasing sources
    run(4'd8, 2'd3, 2'd0, 2'd0, 8'hA5);
    for (int i = 0; i < 10; i++)
      run(4'($urandom_range(0, 9)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    run(4'd0, 2'd1, 2'd1, 2'd1, 8'h00);

    // Illegal opcode: error response, nothing written, next command normal
    run(4'd8, 2'd1, 2'd0, 2'd0, 8'h3C);
    run(4'hC, 2'd1, 2'd0, 2'd2, 8'h00);
    run(4'hF, 2'd2, 2'd3, 2'd3, 8'h77);
    run(4'd8, 2'd1, 2'd0, 2'd0, 8'h55);

    // Reset in the middle of a MUL
    run(4'd8, 2'd0, 2'd0, 2'd0, 8'h0D);
    issue(4'd9, 2'd2, 2'd0, 2'd0, 8'h00);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) sh_regs[i] = 8'h00;
    sh_flags = 4'b0000;
    #1 check_cleared("mul_abort");
    repeat (3) begin
      @(negedge clk);
      check("no_rsp_in_reset", 16'(rsp_valid), 16'd0);
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("no_stale_rsp", 16'(rsp_valid), 16'd0);
    end
    run(4'd0, 2'd3, 2'd1, 2'd2, 8'h00);
    check("add_zero_flags", 16'(flags), 16'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-driven controller that owns the 4x8-bit register file and NZVC flag register, and drives the combinational 8-bit ALU as its initiator. It accepts one instruction at a time over a valid/ready handshake and presents each operand pair and SEL code to the ALU. It captures RESULT and NZVC into the register file and flags, and signals completion with a one-cycle response. It also adds LDI (load immediate) and MUL (iterative shift-add multiply) on top of the ALU's eight operations.

Parameters:
NREG, 4, number of 8-bit registers (index width 2; fixed at 4 for this revision)
MUL_STEPS, 8, shift-add iterations for MUL (equals data width)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  instruction present
cmd_ready  out  1  controller can accept; equals (state==IDLE)
cmd_op  in  4  0-7 ALU SEL pass-through, 8 LDI, 9 MUL, 10-15 illegal
cmd_rd  in  2  destination register
cmd_ra  in  2  source A register
cmd_rb  in  2  source B register
cmd_imm  in  8  immediate for LDI
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  qualified by rsp_valid; 1 = illegal opcode
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_sel  out  3  ALU SEL
alu_result  in  8  ALU RESULT
alu_nzvc  in  4  ALU NZVC {N,Z,V,C}
flags  out  4  flag register {N,Z,V,C}
dbg_sel  in  2  register readout select
dbg_data  out  8  combinational readout of reg[dbg_sel]

Behaviour:
- Reset (async, rst_n low): state IDLE, all regs 0x00, flags 0000, rsp_valid 0, rsp_err 0, alu_a/alu_b/alu_sel 0. Any in-progress MUL is discarded. No accept occurs while rst_n is low.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - cmd_ready=1.
  - Accept on a rising edge with cmd_valid=1.
  - Latch op, rd, imm, opA=reg[ra], opB=reg[rb]. ra==rb is legal.
  - Go to MUL if op==9, else EXEC.
- EXEC (1 cycle):
  - alu_a=opA, alu_b=opB, alu_sel=op[2:0]. Outputs are registered from latched operands.
  - At the end of the cycle, by op:
    - 0,1,4-7: reg[rd]<=alu_result; flags<=alu_nzvc.
    - 2,3 (AND/OR): reg[rd]<=alu_result; flags N,Z <= alu_nzvc[3:2]; V,C unchanged.
    - 8 (LDI): reg[rd]<=imm; N<=imm[7]; Z<=(imm==0); V,C unchanged. ALU not used.
    - 10-15: no register or flag write; set err.
  - Then go to DONE.
- MUL (MUL_STEPS cycles):
  - Init on accept: acc=0, mc=opA, mp=opB, lost=0, cy=0, cnt=0.
  - Each cycle: alu_sel=000 (ADD), alu_a=acc, alu_b=mc.
  - If mp[0]=1: acc<=alu_result; cy<=cy|alu_nzvc[0]|lost.
  - Every cycle: lost<=lost|mc[7]; mc<=mc<<1; mp<=mp>>1; cnt<=cnt+1.
  - After the 8th cycle: reg[rd]<=final acc; flags <= {acc[7], acc==0, 0, cy}. C=1 exactly when the unsigned 16-bit product > 255.
  - Then go to DONE.
- DONE (1 cycle): rsp_valid=1, rsp_err=err. Return to IDLE; err cleared.
- Latency, counting the cycle after the accept edge as cycle 1:
  - ALU/LDI/illegal: rsp_valid in cycle 2.
  - MUL: rsp_valid in cycle 9.
  - Back-to-back issue: next accept possible at the edge ending cycle 3 (ALU) or cycle 10 (MUL).
- rd==ra or rd==rb: operands are latched at accept, so the result is written without hazard.
- Writeback is visible on dbg_data the cycle after the write edge.
- cmd_* inputs are ignored outside IDLE.
- Width rules: all data is 8-bit. MUL keeps the low byte only. The ALU carry-out is taken solely from alu_nzvc[0].

Test Plan:
1. Reset, then LDI r0=0x7F, LDI r1=0x01, ADD rd=r2 ra=r0 rb=r1 -> r2=0x80, flags=1010, rsp_valid exactly 2 cycles after the ADD accept, rsp_err=0.
2. LDI r0=0x05, SUB r3=r0-r0 -> r3=0x00, flags=0100. Then LDI r1=0xF0 -> flags=1000 (N=1, Z=0, V/C held from the SUB).
3. Set C=1 via ADD 0xFF+0x01, then AND 0xF0&0x0F -> result 0x00, flags N=0 Z=1 with V and C unchanged from the ADD.
4. MUL 0x0D*0x0B -> rd=0x8F, flags=1000, rsp_valid 9 cycles after accept. MUL 0x10*0x10 -> rd=0x00, flags=0101. MUL 0xFF*0x01 -> 0xFF, C=0.
5. Illegal cmd_op=0xC with rd=r1 -> rsp_valid with rsp_err=1; r1 and flags unchanged; next command accepted normally.
6. Drop rst_n low in MUL cycle 4 -> immediately all regs 0, flags 0000, cmd_ready=1, no rsp_valid. After release, ADD 0+0 -> flags=0100.
